// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LS memory port arbiter: owner tags, FSM states and the NOP fetch word.
package mem_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_LS} arb_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic arb_state_e wait_state(owner_e o);
    return (o == OWN_LS) ? WAIT_LS : WAIT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        flush_i;
  logic        if_stall_o;
  logic        if_valid_o;
  logic [31:0] if_data_o;

  logic        ls_req_i;
  logic [3:0]  ls_we_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_stall_o;
  logic        ls_valid_o;
  logic [31:0] ls_rdata_o;

  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    input  mem_ready_i, mem_rdata_i,
    output if_stall_o, if_valid_o, if_data_o,
    output ls_stall_o, ls_valid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    output mem_ready_i, mem_rdata_i,
    input  if_stall_o, if_valid_o, if_data_o,
    input  ls_stall_o, ls_valid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch and load/store; LS has priority
// with a starvation guard, the owner is locked through wait states.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] NOP_WORD     = NOP_INSTR
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_e  state, state_d;
  owner_e      owner, resp_owner;
  logic [2:0]  starve_cnt;
  logic        kill_q;
  logic        mem_req, accept;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        if_resp, ls_resp, if_kill;
  logic [31:0] if_data_q, if_data_d, ls_rdata_q;

  // A locked owner that drops its request releases the port without an access.
  always_comb begin
    owner = OWN_NONE;
    case (state)
      IDLE: begin
        if (bus.ls_req_i && (!bus.if_req_i || 32'(starve_cnt) < STARVE_LIMIT))
          owner = OWN_LS;
        else if (bus.if_req_i)
          owner = OWN_IF;
      end
      WAIT_IF: if (bus.if_req_i) owner = OWN_IF;
      WAIT_LS: if (bus.ls_req_i) owner = OWN_LS;
      default: owner = OWN_NONE;
    endcase
    if (!reset_n) owner = OWN_NONE;
  end

  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_IF: mem_addr = bus.if_addr_i & ~32'h3;
      OWN_LS: begin
        mem_we    = bus.ls_we_i;
        mem_addr  = bus.ls_addr_i;
        mem_wdata = bus.ls_wdata_i;
      end
      default: ;
    endcase
  end

  assign mem_req = (owner != OWN_NONE);
  assign accept  = mem_req && bus.mem_ready_i;

  always_comb begin
    state_d = IDLE;
    if (mem_req && !bus.mem_ready_i) state_d = wait_state(owner);
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;

  assign bus.if_stall_o = reset_n && bus.if_req_i && !(accept && owner == OWN_IF);
  assign bus.ls_stall_o = reset_n && bus.ls_req_i && !(accept && owner == OWN_LS);

  // Flush kills both a response arriving now and one whose request is accepted now.
  assign if_resp   = reset_n && (resp_owner == OWN_IF);
  assign ls_resp   = reset_n && (resp_owner == OWN_LS);
  assign if_kill   = kill_q || bus.flush_i;
  assign if_data_d = if_kill ? NOP_WORD : bus.mem_rdata_i;

  assign bus.if_valid_o = if_resp && !if_kill;
  assign bus.if_data_o  = if_resp ? if_data_d : if_data_q;
  assign bus.ls_valid_o = ls_resp;
  assign bus.ls_rdata_o = ls_resp ? bus.mem_rdata_i : ls_rdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      resp_owner <= OWN_NONE;
      kill_q     <= 1'b0;
      starve_cnt <= '0;
      if_data_q  <= NOP_WORD;
      ls_rdata_q <= '0;
    end else begin
      state      <= state_d;
      resp_owner <= accept ? owner : OWN_NONE;
      kill_q     <= accept && (owner == OWN_IF) && bus.flush_i;
      if (!bus.if_req_i || (accept && owner == OWN_IF))
        starve_cnt <= '0;
      else if (accept && owner == OWN_LS && starve_cnt != '1)
        starve_cnt <= starve_cnt + 3'd1;
      if (if_resp) if_data_q  <= if_data_d;
      if (ls_resp) ls_rdata_q <= bus.mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .NOP_WORD(NOP)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_f(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the port (0 none, 1 IF, 2 LS), LS-run count, pending response.
  int          m_lock = 0, m_starve = 0, m_resp = 0;
  bit          m_kill = 0, m_resp_rd = 0, m_ls_known = 1;
  logic [31:0] m_resp_addr = '0, m_if_held = NOP, m_ls_held = '0;
  int          c_who;
  bit          c_acc, c_kill;
  logic [31:0] c_addr;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_mem_req", bus.mem_req_o, 0);
      chk("rst_if_stall", bus.if_stall_o, 0);
      chk("rst_ls_stall", bus.ls_stall_o, 0);
      chk("rst_if_valid", bus.if_valid_o, 0);
      chk("rst_ls_valid", bus.ls_valid_o, 0);
      m_lock = 0; m_starve = 0; m_resp = 0; m_kill = 0;
      m_if_held = NOP; m_ls_held = '0; m_ls_known = 1;
    end else begin
      c_who = 0;
      if (m_lock == 0) begin
        if (bus.ls_req_i && (!bus.if_req_i || m_starve < LIMIT)) c_who = 2;
        else if (bus.if_req_i) c_who = 1;
      end else if (m_lock == 1 && bus.if_req_i) c_who = 1;
      else if (m_lock == 2 && bus.ls_req_i) c_who = 2;
      c_addr = (c_who == 1) ? {bus.if_addr_i[31:2], 2'b00} : bus.ls_addr_i;
      c_acc  = (c_who != 0) && bus.mem_ready_i;

      chk("mdl_mem_req", bus.mem_req_o, c_who != 0);
      if (c_who != 0) chk("mdl_mem_addr", bus.mem_addr_o, c_addr);
      if (c_who == 1) chk("mdl_mem_we_if", bus.mem_we_o, 0);
      if (c_who == 2) begin
        chk("mdl_mem_we_ls", bus.mem_we_o, bus.ls_we_i);
        chk("mdl_mem_wdata", bus.mem_wdata_o, bus.ls_wdata_i);
      end
      chk("mdl_if_stall", bus.if_stall_o, bus.if_req_i && !(c_acc && c_who == 1));
      chk("mdl_ls_stall", bus.ls_stall_o, bus.ls_req_i && !(c_acc && c_who == 2));

      if (m_resp == 1) begin
        c_kill = m_kill || bus.flush_i;
        m_if_held = c_kill ? NOP : mem_f(m_resp_addr);
        chk("mdl_if_valid", bus.if_valid_o, !c_kill);
      end else begin
        chk("mdl_if_valid", bus.if_valid_o, 0);
      end
      chk("mdl_if_data", bus.if_data_o, m_if_held);

      chk("mdl_ls_valid", bus.ls_valid_o, m_resp == 2);
      if (m_resp == 2) begin
        m_ls_known = m_resp_rd;
        m_ls_held  = mem_f(m_resp_addr);
      end
      if (m_ls_known) chk("mdl_ls_rdata", bus.ls_rdata_o, m_ls_held);

      if (!bus.if_req_i || (c_acc && c_who == 1)) m_starve = 0;
      else if (c_acc && c_who == 2 && m_starve < 7) m_starve++;
      m_lock      = (c_who != 0 && !bus.mem_ready_i) ? c_who : 0;
      m_resp      = c_acc ? c_who : 0;
      m_kill      = c_acc && c_who == 1 && bus.flush_i;
      m_resp_addr = c_addr;
      m_resp_rd   = (c_who == 1) || (bus.ls_we_i == 4'h0);
    end
  end

  // Memory returns data only in the cycle after an accept; otherwise noise.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.mem_rdata_i = (m_resp != 0) ? mem_f(m_resp_addr) : $urandom;
  endtask

  task automatic set_in(bit ifr, logic [31:0] ifa, bit fl, bit lsr, logic [3:0] we,
                        logic [31:0] lsa, logic [31:0] lsw, bit rdy);
    bus.if_req_i = ifr; bus.if_addr_i = ifa; bus.flush_i = fl;
    bus.ls_req_i = lsr; bus.ls_we_i = we; bus.ls_addr_i = lsa; bus.ls_wdata_i = lsw;
    bus.mem_ready_i = rdy;
  endtask

  bit ig, prev_ig;

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_rdata_i = '0;
    repeat (3) tick();

    // Reset state
    reset_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("reset_if_data", bus.if_data_o, 32'h00000013);
    chk("reset_ls_rdata", bus.ls_rdata_o, 0);
    chk("reset_if_valid", bus.if_valid_o, 0);
    chk("reset_mem_req", bus.mem_req_o, 0);
    tick();

    // Fetch-only streaming
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'(i * 4), 0, 0, 0, 0, 0, 1);
      #2;
      chk("ifonly_stall", bus.if_stall_o, 0);
      chk("ifonly_addr", bus.mem_addr_o, 32'(i * 4));
      if (i > 0) begin
        chk("ifonly_valid", bus.if_valid_o, 1);
        chk("ifonly_data", bus.if_data_o, mem_f(32'((i - 1) * 4)));
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("ifonly_last_valid", bus.if_valid_o, 1);
    chk("ifonly_last_data", bus.if_data_o, mem_f(32'hC));
    tick();

    // Both pending: four LS grants, then one forced IF grant
    prev_ig = 0;
    for (int k = 0; k < 10; k++) begin
      set_in(1, 32'h80, 0, 1, 4'h0, 32'h200, 0, 1);
      #2;
      ig = (k % 5 == 4);
      chk("grant_ls_stall", bus.ls_stall_o, ig);
      chk("grant_if_stall", bus.if_stall_o, !ig);
      chk("grant_addr", bus.mem_addr_o, ig ? 32'h80 : 32'h200);
      if (k > 0) begin
        chk("grant_if_resp", bus.if_valid_o, prev_ig);
        chk("grant_ls_resp", bus.ls_valid_o, !prev_ig);
      end
      prev_ig = ig;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("grant_last_if_resp", bus.if_valid_o, 1);
    tick();

    // LS write held through three wait states; IF must not steal the port
    for (int w = 0; w < 4; w++) begin
      set_in(1, 32'h300, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, w == 3);
      #2;
      chk("wr_mem_req", bus.mem_req_o, 1);
      chk("wr_mem_addr", bus.mem_addr_o, 32'h100);
      chk("wr_mem_we", bus.mem_we_o, 4'hF);
      chk("wr_mem_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
      chk("wr_ls_stall", bus.ls_stall_o, w != 3);
      chk("wr_if_stall", bus.if_stall_o, 1);
      tick();
    end
    set_in(1, 32'h300, 0, 0, 0, 0, 0, 1);
    #2;
    chk("wr_ack", bus.ls_valid_o, 1);
    chk("wr_if_after", bus.if_stall_o, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("wr_if_data", bus.if_data_o, mem_f(32'h300));
    tick();

    // Flush in the accept cycle kills the response
    set_in(1, 32'h40, 1, 0, 0, 0, 0, 1);
    #2;
    chk("flush_accept", bus.if_stall_o, 0);
    chk("flush_addr", bus.mem_addr_o, 32'h40);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("flush_valid", bus.if_valid_o, 0);
    chk("flush_data", bus.if_data_o, 32'h00000013);
    tick();

    // Reset while LS waits on memory
    set_in(0, 0, 0, 1, 4'h0, 32'h180, 0, 0);
    #2;
    chk("rstw_ls_stall", bus.ls_stall_o, 1);
    tick();
    #2;
    chk("rstw_locked_addr", bus.mem_addr_o, 32'h180);
    tick();
    reset_n = 1'b0;
    bus.mem_ready_i = 1'b1;
    #2;
    chk("rstw_req_forced", bus.mem_req_o, 0);
    tick();
    reset_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("rstw_ls_valid", bus.ls_valid_o, 0);
    chk("rstw_if_valid", bus.if_valid_o, 0);
    chk("rstw_ls_rdata", bus.ls_rdata_o, 0);
    chk("rstw_if_data", bus.if_data_o, 32'h00000013);
    tick();

    // Randomized traffic; locked requesters usually hold their inputs
    for (int n = 0; n < 3000; n++) begin
      reset_n         = ($urandom % 256) != 0;
      bus.flush_i     = ($urandom % 6) == 0;
      bus.mem_ready_i = ($urandom % 10) < 6;
      if (!(m_lock == 1 && ($urandom % 8) != 0)) begin
        bus.if_req_i  = ($urandom % 3) != 0;
        bus.if_addr_i = $urandom;
      end
      if (!(m_lock == 2 && ($urandom % 8) != 0)) begin
        bus.ls_req_i   = $urandom % 2;
        bus.ls_we_i    = ($urandom % 2) ? 4'h0 : 4'($urandom);
        bus.ls_addr_i  = $urandom;
        bus.ls_wdata_i = $urandom;
      end
      tick();
    end

    reset_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
